// File: rtl/branch_cmp_pkg.sv
// Shared types for the branch compare scheduler: compare opcodes, the per-lane
// request bundle and the compare evaluation helper.
package branch_cmp_pkg;

  typedef enum logic [1:0] {
    CMP_RSV = 2'b00,
    CMP_LT  = 2'b01,
    CMP_LTU = 2'b10,
    CMP_EQ  = 2'b11
  } cmp_op_e;

  // Widest ROB tag the request bundle can carry; narrower tags are zero-extended.
  localparam int unsigned TAG_W_MAX = 16;
  localparam logic [15:0] STAT_MAX  = 16'hFFFF;

  typedef struct packed {
    logic [31:0]          a;
    logic [31:0]          b;
    cmp_op_e              op;
    logic                 inv;
    logic [TAG_W_MAX-1:0] tag;
  } cmp_req_t;

  // Returns {taken, err}; a reserved op never reports taken.
  function automatic logic [1:0] cmp_eval(input cmp_req_t r);
    logic raw;
    logic err;
    raw = 1'b0;
    err = 1'b0;
    case (r.op)
      CMP_EQ:  raw = (r.a == r.b);
      CMP_LT:  raw = ($signed(r.a) < $signed(r.b));
      CMP_LTU: raw = (r.a < r.b);
      default: err = 1'b1;
    endcase
    return {(err ? 1'b0 : (raw ^ r.inv)), err};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: on contention the pointer lane wins,
// otherwise the single requester is granted.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    // NOTE: assign a default before any conditional so no latch is inferred.
    gnt = req;
    if (req == 2'b11) gnt = ptr ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/branch_cmp_scheduler.sv
// Two-lane branch compare scheduler sharing one 32-bit comparator, with a
// single-entry result register. Define BRANCH_CMP_STATS_EN for grant counters.
module branch_cmp_scheduler
  import branch_cmp_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][31:0]      req_a,
  input  logic [1:0][31:0]      req_b,
  input  logic [1:0][1:0]       req_op,
  input  logic [1:0]            req_inv,
  input  logic [1:0][TAG_W-1:0] req_tag,
  input  logic                  flush,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_taken,
  output logic [TAG_W-1:0]      res_tag,
  output logic                  res_lane,
  output logic                  res_err,
  output logic [15:0]           stat_cnt0,
  output logic [15:0]           stat_cnt1
);

  logic       ptr_q;
  logic [1:0] gnt;
  logic       can_load;
  logic [1:0] xfer;
  logic       fire;
  logic       sel_lane;
  cmp_req_t   sel;
  logic [1:0] cmp_res;
  logic       tag_hi_unused;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // A slot opens when the register is empty or being drained this cycle.
  assign can_load  = (!res_valid || res_ready) && !flush && !rst;
  assign req_ready = can_load ? gnt : 2'b00;
  assign xfer      = req_valid & req_ready;
  assign fire      = |xfer;
  assign sel_lane  = xfer[1];

  always_comb begin
    sel.a   = req_a[sel_lane];
    sel.b   = req_b[sel_lane];
    sel.op  = cmp_op_e'(req_op[sel_lane]);
    sel.inv = req_inv[sel_lane];
    sel.tag = TAG_W_MAX'(req_tag[sel_lane]);
  end

  assign cmp_res       = cmp_eval(sel);
  assign tag_hi_unused = ^sel.tag;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (rst) begin
      res_valid <= 1'b0;
      res_taken <= 1'b0;
      res_tag   <= '0;
      res_lane  <= 1'b0;
      res_err   <= 1'b0;
      ptr_q     <= 1'b0;
    end else if (fire) begin
      res_valid <= 1'b1;
      res_taken <= cmp_res[1];
      res_tag   <= sel.tag[TAG_W-1:0];
      res_lane  <= sel_lane;
      res_err   <= cmp_res[0];
      ptr_q     <= ~sel_lane;
    end else if (flush || res_ready) begin
      res_valid <= 1'b0;
    end
  end

`ifdef BRANCH_CMP_STATS_EN
  logic [15:0] cnt0_q;
  logic [15:0] cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (xfer[0] && cnt0_q != STAT_MAX) cnt0_q <= cnt0_q + 16'd1;
      if (xfer[1] && cnt1_q != STAT_MAX) cnt1_q <= cnt1_q + 16'd1;
    end
  end

  assign stat_cnt0 = cnt0_q;
  assign stat_cnt1 = cnt1_q;
`else
  assign stat_cnt0 = '0;
  assign stat_cnt1 = '0;
`endif

endmodule

// File: tb/tb_branch_cmp_scheduler.sv
// Directed + random bench for branch_cmp_scheduler using a result scoreboard
// and a reference arbitration model.
module tb_branch_cmp_scheduler;

  localparam int TAG_W = 4;

  typedef struct {
    logic             taken;
    logic [TAG_W-1:0] tag;
    logic             lane;
    logic             err;
  } exp_t;

  logic                  clk;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][31:0]      req_a;
  logic [1:0][31:0]      req_b;
  logic [1:0][1:0]       req_op;
  logic [1:0]            req_inv;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  flush;
  logic                  res_valid;
  logic                  res_ready;
  logic                  res_taken;
  logic [TAG_W-1:0]      res_tag;
  logic                  res_lane;
  logic                  res_err;
  logic [15:0]           stat_cnt0;
  logic [15:0]           stat_cnt1;

  int tests = 0;
  int fails = 0;

  exp_t        sb[$];
  logic        rv_m   = 1'b0;
  logic        ptr_m  = 1'b0;
  logic [15:0] cnt0_m = '0;
  logic [15:0] cnt1_m = '0;

  branch_cmp_scheduler #(.TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .req_inv   (req_inv),
    .req_tag   (req_tag),
    .flush     (flush),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_taken (res_taken),
    .res_tag   (res_tag),
    .res_lane  (res_lane),
    .res_err   (res_err),
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic ln);
    exp_t e;
    logic raw;
    logic [31:0] a;
    logic [31:0] b;
    a = req_a[ln];
    b = req_b[ln];
    raw = 1'b0;
    e.err = 1'b0;
    if (req_op[ln] == 2'b11)      raw = (a == b);
    else if (req_op[ln] == 2'b01) raw = ($signed(a) < $signed(b));
    else if (req_op[ln] == 2'b10) raw = (a < b);
    else                          e.err = 1'b1;
    e.taken = e.err ? 1'b0 : (raw ^ req_inv[ln]);
    e.tag   = req_tag[ln];
    e.lane  = ln;
    return e;
  endfunction

  // Checks the current cycle against the model, advances the model, then
  // steps one clock and returns 1 time unit after the rising edge.
  task automatic tick();
    logic [1:0] gm;
    logic [1:0] er;
    logic       can;
    logic       ln;
    #1;
    can = (!rv_m || res_ready) && !flush && !rst;
    gm  = req_valid;
    if (req_valid == 2'b11) gm = ptr_m ? 2'b10 : 2'b01;
    er = can ? gm : 2'b00;
    check("req_ready", req_ready, er);
    check("res_valid", res_valid, rv_m);
    if (rv_m) begin
      check("res_taken", res_taken, sb[0].taken);
      check("res_tag",   res_tag,   sb[0].tag);
      check("res_lane",  res_lane,  sb[0].lane);
      check("res_err",   res_err,   sb[0].err);
    end
    check("stat_cnt0", stat_cnt0, cnt0_m);
    check("stat_cnt1", stat_cnt1, cnt1_m);
    if (rst) begin
      rv_m = 1'b0;
      sb.delete();
      ptr_m  = 1'b0;
      cnt0_m = '0;
      cnt1_m = '0;
    end else begin
      if (rv_m && (res_ready || flush)) begin
        void'(sb.pop_front());
        rv_m = 1'b0;
      end
      if (er != 2'b00) begin
        ln = er[1];
        sb.push_back(predict(ln));
        rv_m  = 1'b1;
        ptr_m = ~ln;
`ifdef BRANCH_CMP_STATS_EN
        if (ln) begin
          if (cnt1_m != 16'hFFFF) cnt1_m++;
        end else begin
          if (cnt0_m != 16'hFFFF) cnt0_m++;
        end
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int ln, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic inv, input logic [TAG_W-1:0] tag);
    req_a[ln]   = a;
    req_b[ln]   = b;
    req_op[ln]  = op;
    req_inv[ln] = inv;
    req_tag[ln] = tag;
  endtask

  initial begin
    logic [TAG_W-1:0] held_tag;
    logic             held_taken;
    rst       = 1'b1;
    flush     = 1'b0;
    res_ready = 1'b1;
    req_valid = 2'b11;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_inv   = '0;
    req_tag   = '0;
    @(posedge clk);
    #1;

    // Reset: ready forced low even with both lanes requesting.
    tick();
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    check("rst_taken", res_taken, 1'b0);
    check("rst_tag",   res_tag,   '0);
    check("rst_lane",  res_lane,  1'b0);
    check("rst_err",   res_err,   1'b0);
    check("rst_cnt0",  stat_cnt0, 16'h0);
    check("rst_cnt1",  stat_cnt1, 16'h0);

    // Round-robin order with both lanes valid, no bubble.
    set_lane(0, 32'd1, 32'd2, 2'b01, 1'b0, 4'd1);
    set_lane(1, 32'd7, 32'd7, 2'b11, 1'b1, 4'd2);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rr_valid", res_valid, 1'b1);
      check("rr_lane",  res_lane,  i[0]);
    end
    req_valid = 2'b00;
    tick();

    // Lane0 EQ.
    set_lane(0, 32'd5, 32'd5, 2'b11, 1'b0, 4'd3);
    set_lane(1, 32'hDEAD, 32'hBEEF, 2'b00, 1'b1, 4'd15);
    req_valid = 2'b01;
    tick();
    check("eq_valid", res_valid, 1'b1);
    check("eq_taken", res_taken, 1'b1);
    check("eq_tag",   res_tag,   4'd3);
    check("eq_lane",  res_lane,  1'b0);

    // Lane1 signed vs unsigned, inverted; lane0 fields are junk.
    set_lane(0, 32'h0, 32'h0, 2'b00, 1'b1, 4'd9);
    set_lane(1, 32'hFFFFFFFF, 32'd1, 2'b01, 1'b0, 4'd6);
    req_valid = 2'b10;
    tick();
    check("lt_taken", res_taken, 1'b1);
    req_op[1] = 2'b10;
    tick();
    check("ltu_taken", res_taken, 1'b0);
    req_inv[1] = 1'b1;
    tick();
    check("geu_taken", res_taken, 1'b1);
    check("geu_lane",  res_lane,  1'b1);
    req_valid = 2'b00;
    tick();

    // Backpressure: result held 3 cycles, then drain and grant together.
    set_lane(0, 32'd10, 32'd3, 2'b10, 1'b0, 4'd5);
    req_valid = 2'b01;
    tick();
    held_tag   = res_tag;
    held_taken = res_taken;
    set_lane(1, 32'd4, 32'd4, 2'b11, 1'b0, 4'd9);
    req_valid = 2'b11;
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_valid", res_valid, 1'b1);
      check("hold_tag",   res_tag,   held_tag);
      check("hold_taken", res_taken, held_taken);
      check("hold_lane",  res_lane,  1'b0);
    end
    res_ready = 1'b1;
    tick();
    check("drain_valid", res_valid, 1'b1);
    check("drain_lane",  res_lane,  1'b1);
    check("drain_tag",   res_tag,   4'd9);
    tick();
    check("next_lane", res_lane, 1'b0);
    req_valid = 2'b00;
    tick();

    // Flush with a held result and lane0 pending.
    set_lane(0, 32'd8, 32'd8, 2'b11, 1'b0, 4'd4);
    req_valid = 2'b01;
    tick();
    res_ready = 1'b0;
    flush     = 1'b1;
    tick();
    check("flush_valid", res_valid, 1'b0);
    flush     = 1'b0;
    res_ready = 1'b1;
    req_valid = 2'b11;
    tick();
    check("flush_ptr_lane", res_lane, 1'b1);
    req_valid = 2'b00;
    tick();

    // Reserved op.
    set_lane(0, 32'd1, 32'd1, 2'b00, 1'b1, 4'd7);
    req_valid = 2'b01;
    tick();
    check("rsv_err",   res_err,   1'b1);
    check("rsv_taken", res_taken, 1'b0);
    req_valid = 2'b00;
    tick();

    // Reset mid-operation discards a pending result.
    set_lane(0, 32'd2, 32'd1, 2'b01, 1'b0, 4'd8);
    req_valid = 2'b01;
    res_ready = 1'b0;
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    tick();
    check("midrst_valid", res_valid, 1'b0);
    rst = 1'b0;
    res_ready = 1'b1;
    tick();
    check("midrst_none", res_valid, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < 2; l++) begin
        logic [31:0] a;
        a = $urandom;
        set_lane(l, a, ($urandom_range(0, 2) == 0) ? a : $urandom,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 TAG_W'($urandom_range(0, 15)));
      end
      req_valid = 2'($urandom_range(0, 3));
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0;
    res_ready = 1'b1;
    req_valid = 2'b00;
    tick();

    // Grant counters: lane1 only after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_lane(1, 32'd3, 32'd4, 2'b10, 1'b0, 4'd1);
    req_valid = 2'b10;
`ifdef BRANCH_CMP_STATS_EN
    for (int i = 0; i < 65537; i++) tick();
    req_valid = 2'b00;
    tick();
    check("sat_cnt1", stat_cnt1, 16'hFFFF);
    check("sat_cnt0", stat_cnt0, 16'h0);
`else
    for (int i = 0; i < 20; i++) tick();
    req_valid = 2'b00;
    tick();
    check("tied_cnt1", stat_cnt1, 16'h0);
    check("tied_cnt0", stat_cnt0, 16'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
